// File: rtl/multiword_add_sequencer.sv
// multiword_add_sequencer
//   Sequences a WORDS*WIDTH-bit add through one external combinational
//   WIDTH-bit adder. It processes one word per cycle, least-significant word
//   first, and keeps the carry between words in a register.
//   Optional feature macro: SUBTRACT_EN adds the Sub port, which selects
//   OpA - OpB: the B words are inverted and the initial carry is forced to 1.
module multiword_add_sequencer #(
   parameter int WIDTH = 32,
   parameter int WORDS = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     Start,
   input  logic [WORDS*WIDTH-1:0]   OpA,
   input  logic [WORDS*WIDTH-1:0]   OpB,
   input  logic                     Cin,
`ifdef SUBTRACT_EN
   input  logic                     Sub,
`endif
   output logic [WIDTH-1:0]         AddA,
   output logic [WIDTH-1:0]         AddB,
   output logic                     AddCin,
   input  logic [WIDTH-1:0]         AddSum,
   input  logic                     AddCout,
   output logic [WORDS*WIDTH-1:0]   Result,
   output logic                     Cout,
   output logic                     Busy,
   output logic                     Done
);

   localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int OPW   = WORDS * WIDTH;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]        r_state;
   logic [IDX_W-1:0]  r_idx;
   logic              r_carry;
   logic [OPW-1:0]    r_opa;
   logic [OPW-1:0]    r_opb;
   logic [OPW-1:0]    r_result;
   logic              r_cout;
   logic              r_done;
`ifdef SUBTRACT_EN
   logic              r_sub;
`endif

   logic [WIDTH-1:0]  w_a_words [WORDS];
   logic [WIDTH-1:0]  w_b_words [WORDS];
   logic [WORDS-1:0]  w_word_sel;
   logic [WIDTH-1:0]  w_a_sel;
   logic [WIDTH-1:0]  w_b_sel;
   logic [WIDTH-1:0]  w_b_drive;
   logic              w_run;
   logic              w_last;
   logic              w_init_carry;

   // Split the operand registers into words and decode the active word.
   genvar gi;
   generate
      for (gi = 0; gi < WORDS; gi++) begin : g_words
         assign w_a_words[gi]  = r_opa[gi*WIDTH +: WIDTH];
         assign w_b_words[gi]  = r_opb[gi*WIDTH +: WIDTH];
         assign w_word_sel[gi] = (r_idx == IDX_W'(gi));
      end
   endgenerate

   assign w_run  = (r_state == S_RUN);
   assign w_last = (r_idx == IDX_W'(WORDS - 1));

`ifdef SUBTRACT_EN
   // A subtraction starts with carry 1 to complete the two's complement of B.
   assign w_init_carry = Sub ? 1'b1 : Cin;
   assign w_b_drive    = r_sub ? ~w_b_sel : w_b_sel;
`else
   assign w_init_carry = Cin;
   assign w_b_drive    = w_b_sel;
`endif

   // Select the operand words that feed the shared adder this cycle.
   always_comb begin
      w_a_sel = '0;
      w_b_sel = '0;
      for (int i = 0; i < WORDS; i++) begin
         if (w_word_sel[i]) begin
            w_a_sel = w_a_words[i];
            w_b_sel = w_b_words[i];
         end
      end
   end

   // The adder inputs are quiet (all zero) outside RUN.
   always_comb begin
      AddA   = w_run ? w_a_sel   : '0;
      AddB   = w_run ? w_b_drive : '0;
      AddCin = w_run & r_carry;
   end

   assign Result = r_result;
   assign Cout   = r_cout;
   assign Busy   = (r_state != S_IDLE);
   assign Done   = r_done;

   // Control FSM, operand capture and per-word result capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_idx    <= '0;
         r_carry  <= 1'b0;
         r_opa    <= '0;
         r_opb    <= '0;
         r_result <= '0;
         r_cout   <= 1'b0;
         r_done   <= 1'b0;
`ifdef SUBTRACT_EN
         r_sub    <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (Start) begin
                  r_opa    <= OpA;
                  r_opb    <= OpB;
                  r_carry  <= w_init_carry;
                  r_idx    <= '0;
                  r_result <= '0;
`ifdef SUBTRACT_EN
                  r_sub    <= Sub;
`endif
                  r_state  <= S_RUN;
               end
            end
            S_RUN: begin
               for (int i = 0; i < WORDS; i++) begin
                  if (w_word_sel[i]) begin
                     r_result[i*WIDTH +: WIDTH] <= AddSum;
                  end
               end
               r_carry <= AddCout;
               r_idx   <= r_idx + IDX_W'(1);
               if (w_last) begin
                  r_cout  <= AddCout;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               // Done is registered, so it pulses in the first cycle back in IDLE.
               r_done  <= 1'b1;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Testbench for multiword_add_sequencer (WIDTH=32, WORDS=4) with a
// behavioural model of the external combinational adder.
module tb_multiword_add_sequencer;

   localparam int WIDTH = 32;
   localparam int WORDS = 4;
   localparam int OPW   = WIDTH * WORDS;

   logic              clk = 1'b0;
   logic              rst;
   logic              Start;
   logic [OPW-1:0]    OpA;
   logic [OPW-1:0]    OpB;
   logic              Cin;
   logic              Sub_in;
   logic [WIDTH-1:0]  AddA;
   logic [WIDTH-1:0]  AddB;
   logic              AddCin;
   logic [WIDTH-1:0]  AddSum;
   logic              AddCout;
   logic [OPW-1:0]    Result;
   logic              Cout;
   logic              Busy;
   logic              Done;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   // External ripple adder: purely combinational.
   assign {AddCout, AddSum} = {1'b0, AddA} + {1'b0, AddB} + {{WIDTH{1'b0}}, AddCin};

   multiword_add_sequencer #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
      .clk     (clk),
      .rst     (rst),
      .Start   (Start),
      .OpA     (OpA),
      .OpB     (OpB),
      .Cin     (Cin),
`ifdef SUBTRACT_EN
      .Sub     (Sub_in),
`endif
      .AddA    (AddA),
      .AddB    (AddB),
      .AddCin  (AddCin),
      .AddSum  (AddSum),
      .AddCout (AddCout),
      .Result  (Result),
      .Cout    (Cout),
      .Busy    (Busy),
      .Done    (Done)
   );

   typedef struct {
      logic [OPW-1:0] a;
      logic [OPW-1:0] b;
      logic           cin;
      logic           sub;
      logic [OPW-1:0] exp_res;
      logic           exp_co;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [OPW-1:0] act, input logic [OPW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Sample once per falling edge until Done is seen (bounded).
   task automatic wait_done(output int done_n, output int busy_n,
                            output logic [OPW-1:0] res, output logic co);
      done_n = -1;
      busy_n = 0;
      res    = '0;
      co     = 1'b0;
      for (int n = 0; n < 20; n++) begin
         if (n > 0) @(negedge clk);
         if (Busy) busy_n++;
         if (Done) begin
            done_n = n;
            res    = Result;
            co     = Cout;
            break;
         end
      end
   endtask

   // Issue one operation and return what the DUT produced. With imm=1,
   // Start is raised in the current cycle (back-to-back after Done).
   task automatic do_op(input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                        input logic cin, input logic sub, input bit imm,
                        output logic [OPW-1:0] res, output logic co,
                        output int done_n, output int busy_n);
      if (!imm) @(negedge clk);
      OpA    = a;
      OpB    = b;
      Cin    = cin;
      Sub_in = sub;
      Start  = 1'b1;
      @(negedge clk);
      Start  = 1'b0;
      // Operands changing after accept must not matter.
      OpA    = {$urandom, $urandom, $urandom, $urandom};
      OpB    = {$urandom, $urandom, $urandom, $urandom};
      Cin    = ~cin;
      Sub_in = ~sub;
      check("busy_first_cycle", OPW'(Busy), OPW'(1));
      check("done_low_first_cycle", OPW'(Done), OPW'(0));
      wait_done(done_n, busy_n, res, co);
      $display("op a=%h b=%h cin=%0d sub=%0d -> res=%h cout=%0d done_at=%0d busy=%0d",
               a, b, cin, sub, res, co, done_n, busy_n);
   endtask

   initial begin
      logic [OPW-1:0] res;
      logic [OPW-1:0] exp_res;
      logic [OPW-1:0] ones;
      logic           co;
      logic           exp_co;
      logic           sub;
      logic           cin;
      logic [OPW-1:0] a;
      logic [OPW-1:0] b;
      int             done_n;
      int             busy_n;
      int             done_seen;

      ones = '1;

      vecs.push_back('{128'hFFFF_FFFF, 128'h1, 1'b0, 1'b0, 128'h1_0000_0000, 1'b0});
      vecs.push_back('{ones, 128'h0, 1'b1, 1'b0, 128'h0, 1'b1});
      vecs.push_back('{ones, ones, 1'b1, 1'b0, ones, 1'b1});
      vecs.push_back('{128'h8000_0000_0000_0000_0000_0000_0000_0000,
                       128'h8000_0000_0000_0000_0000_0000_0000_0000,
                       1'b0, 1'b0, 128'h0, 1'b1});
      vecs.push_back('{128'h0, 128'h0, 1'b0, 1'b0, 128'h0, 1'b0});
      vecs.push_back('{128'h0000_0001_0000_0000_FFFF_FFFF_FFFF_FFFF, 128'h1, 1'b0, 1'b0,
                       128'h0000_0001_0000_0001_0000_0000_0000_0000, 1'b0});
`ifdef SUBTRACT_EN
      vecs.push_back('{128'd5, 128'd7, 1'b0, 1'b1,
                       128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, 1'b0});
      vecs.push_back('{128'd7, 128'd5, 1'b0, 1'b1, 128'd2, 1'b1});
      vecs.push_back('{128'd7, 128'd5, 1'b0, 1'b0, 128'd12, 1'b0});
`endif

      rst    = 1'b1;
      Start  = 1'b0;
      OpA    = '0;
      OpB    = '0;
      Cin    = 1'b0;
      Sub_in = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("reset_result", Result, '0);
      check("reset_cout", OPW'(Cout), OPW'(0));
      check("reset_busy", OPW'(Busy), OPW'(0));
      check("reset_done", OPW'(Done), OPW'(0));
      check("reset_adda", OPW'(AddA), OPW'(0));
      check("reset_addb", OPW'(AddB), OPW'(0));
      check("reset_addcin", OPW'(AddCin), OPW'(0));

      // Table-driven vectors
      foreach (vecs[i]) begin
         do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, 1'b0, res, co, done_n, busy_n);
         check($sformatf("vec%0d_result", i), res, vecs[i].exp_res);
         check($sformatf("vec%0d_cout", i), OPW'(co), OPW'(vecs[i].exp_co));
         check($sformatf("vec%0d_done_latency", i), OPW'(done_n), OPW'(WORDS + 1));
         check($sformatf("vec%0d_busy_cycles", i), OPW'(busy_n), OPW'(WORDS + 1));
      end

      // Start during RUN is ignored
      @(negedge clk);
      OpA = 128'd12; OpB = 128'd34; Cin = 1'b0; Sub_in = 1'b0; Start = 1'b1;
      @(negedge clk);
      Start = 1'b0;
      check("ignore_adda_word0", OPW'(AddA), OPW'(12));
      check("ignore_addb_word0", OPW'(AddB), OPW'(34));
      @(negedge clk);
      OpA = 128'd78; OpB = 128'd90; Start = 1'b1;
      @(negedge clk);
      Start = 1'b0;
      wait_done(done_n, busy_n, res, co);
      $display("op a=12 b=34 with mid-run Start -> res=%h done_at=%0d", res, done_n);
      check("ignore_result", res, 128'd46);
      check("ignore_done_latency", OPW'(done_n), OPW'(3));
      do_op(128'd78, 128'd90, 1'b0, 1'b0, 1'b0, res, co, done_n, busy_n);
      check("after_ignore_result", res, 128'd168);

      // Reset in the second RUN cycle aborts the operation
      @(negedge clk);
      OpA = 128'h5_0000_0000_0000_0000_0000_0005; OpB = 128'd6; Cin = 1'b1; Start = 1'b1;
      @(negedge clk);
      Start = 1'b0;
      check("run0_adda", OPW'(AddA), OPW'(5));
      check("run0_addb", OPW'(AddB), OPW'(6));
      check("run0_addcin", OPW'(AddCin), OPW'(1));
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_result", Result, '0);
      check("abort_cout", OPW'(Cout), OPW'(0));
      check("abort_busy", OPW'(Busy), OPW'(0));
      check("abort_done", OPW'(Done), OPW'(0));
      check("abort_adda", OPW'(AddA), OPW'(0));
      done_seen = 0;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         if (Done || Busy) done_seen++;
      end
      check("abort_no_done", OPW'(done_seen), OPW'(0));
      do_op(128'd12, 128'd56, 1'b1, 1'b0, 1'b0, res, co, done_n, busy_n);
      check("after_abort_result", res, 128'd69);
      check("after_abort_cout", OPW'(co), OPW'(0));

      // Randomized operations against an arithmetic reference
      for (int t = 0; t < 30; t++) begin
         a = {$urandom, $urandom, $urandom, $urandom};
         b = {$urandom, $urandom, $urandom, $urandom};
         if ($urandom_range(0, 3) == 0) a = ones;
         if ($urandom_range(0, 3) == 0) b[63:0] = '1;
         cin = 1'($urandom_range(0, 1));
`ifdef SUBTRACT_EN
         sub = 1'($urandom_range(0, 1));
`else
         sub = 1'b0;
`endif
         if (sub) {exp_co, exp_res} = {1'b0, a} + {1'b0, ~b} + 129'd1;
         else     {exp_co, exp_res} = {1'b0, a} + {1'b0, b} + {128'd0, cin};
         do_op(a, b, cin, sub, bit'($urandom_range(0, 1)), res, co, done_n, busy_n);
         check($sformatf("rand%0d_result", t), res, exp_res);
         check($sformatf("rand%0d_cout", t), OPW'(co), OPW'(exp_co));
         check($sformatf("rand%0d_done_latency", t), OPW'(done_n), OPW'(WORDS + 1));
      end

      @(negedge clk);
      check("final_done_low", OPW'(Done), OPW'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
